// File: rtl/npu_zp_ctrl.sv
// npu_zp_ctrl: zero-point sequencer for the MAC input path; NPU_ZP_CTRL_PERF_EN adds stall_cnt_o
module npu_zp_ctrl #(
    parameter int I_LEN  = 8,
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(NUM_CH)-1:0] cfg_addr_i,
    input  logic signed [I_LEN-1:0]   cfg_zp_i,
    input  logic                      start_i,
    input  logic [CNT_W-1:0]          len_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic signed [I_LEN-1:0]   s_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic signed [I_LEN-1:0]   m_data_o,
    output logic signed [I_LEN-1:0]   m_zp_o,
    output logic                      m_last_o
`ifdef NPU_ZP_CTRL_PERF_EN
    ,output logic [CNT_W-1:0]         stall_cnt_o
`endif
);
    localparam int CH_W = $clog2(NUM_CH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        len_q, len_d, cnt_q, cnt_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic signed [I_LEN-1:0] tbl_q [NUM_CH];
    logic signed [I_LEN-1:0] tbl_d [NUM_CH];
    logic signed [I_LEN-1:0] data_q, data_d, zp_q, zp_d;
    logic                    valid_q, valid_d, last_q, last_d;
    logic                    in_xfer, out_xfer, cfg_ok;
    assign s_ready_o = state_q == RUN && cnt_q < len_q && (!valid_q || m_ready_i);
    assign in_xfer   = s_valid_i && s_ready_o;
    assign out_xfer  = valid_q && m_ready_i;
    assign cfg_ok    = cfg_we_i && state_q != RUN && ({1'b0, cfg_addr_i} < (CH_W+1)'(NUM_CH));
    assign busy_o    = state_q == RUN;
    assign done_o    = state_q == DONE;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;
    assign m_data_o  = data_q;
    assign m_zp_o    = zp_q;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        tbl_d   = tbl_q;
        data_d  = data_q;
        zp_d    = zp_q;
        valid_d = in_xfer ? 1'b1 : out_xfer ? 1'b0 : valid_q;
        last_d  = out_xfer ? 1'b0 : last_q;
        if (state_q == IDLE && start_i) begin
            state_d = len_i != '0 ? RUN : DONE;
            len_d   = len_i;
            cnt_d   = '0;
            ch_d    = '0;
        end else if (state_q == RUN && out_xfer && last_q) begin
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        if (in_xfer) begin
            data_d = s_data_i;
            zp_d   = tbl_q[ch_q];
            last_d = cnt_q == len_q - CNT_W'(1);
            ch_d   = ch_q == CH_W'(NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
        end
        if (cfg_ok) tbl_d[cfg_addr_i] = cfg_zp_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            tbl_q   <= '{default: '0};
            data_q  <= '0;
            zp_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            tbl_q   <= tbl_d;
            data_q  <= data_d;
            zp_q    <= zp_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end
`ifdef NPU_ZP_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    always_comb begin
        stall_d = (state_q == IDLE && start_i) ? '0 :
                  (state_q == RUN && valid_q && !m_ready_i && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end
    assign stall_cnt_o = stall_q;
`endif
endmodule
